// File: rtl/cic_dec_ctrl_pkg.sv
// cic_dec_ctrl_pkg: shared state encoding and sample rescaling helper for the CIC decimator controller
package cic_dec_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_e;
  localparam int unsigned MIN_RATIO = 2;
  // Logical right shift, then clamp to all ones if anything survives above out_w bits
  function automatic logic [63:0] sat_shift(input logic [63:0] data, input int unsigned shift,
                                            input int unsigned out_w);
    logic [63:0] s;
    logic [63:0] mask;
    s = data >> shift;
    mask = (64'd1 << out_w) - 64'd1;
    return (s & ~mask) != '0 ? mask : s;
  endfunction
endpackage

// File: rtl/cic_dec_phase_cnt.sv
// cic_dec_phase_cnt: wrap counter 0..ratio-1 with synchronous clear and terminal-count strobe
module cic_dec_phase_cnt #(
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clr,
  input  logic [W-1:0] ratio,
  output logic         tc
);
  logic [W-1:0] cnt;
  assign tc = cnt >= ratio - W'(1);
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) cnt <= '0;
    else cnt <= (clr || tc) ? '0 : cnt + W'(1);
endmodule

// File: rtl/cic_dec_ctrl.sv
// cic_dec_ctrl: CIC decimator sequencing (flush, settle, strobe) and scaled sample stream with sticky overflow
module cic_dec_ctrl
  import cic_dec_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = 21,
  parameter int unsigned OUT_W        = 16,
  parameter int unsigned RATIO_W      = 10,
  parameter int unsigned SHIFT_W      = 5,
  parameter int unsigned DEF_RATIO    = 10,
  parameter int unsigned SETTLE_N     = 2,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               enable_i,
  input  logic               cfg_load_i,
  input  logic [RATIO_W-1:0] ratio_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic [DATA_W-1:0]  cic_data_i,
  output logic               dec_stb_o,
  output logic               cic_clr_o,
  output logic [OUT_W-1:0]   out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               ovf_o,
  output logic [1:0]         state_o
);
  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned SW = $clog2(SETTLE_N + 1);
  state_e             state, state_d;
  logic [RATIO_W-1:0] ratio_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [FW-1:0]      flush_cnt;
  logic [SW-1:0]      settle_cnt;
  logic               cap_q, active, tc, flush_done, settle_done, go, new_smp;
  assign active      = state == SETTLE || state == RUN;
  assign go          = enable_i && !cfg_load_i;
  assign flush_done  = flush_cnt == FW'(FLUSH_CYCLES - 1);
  assign settle_done = cap_q && settle_cnt == SW'(SETTLE_N - 1);
  assign new_smp     = go && cap_q && state == RUN;
  assign dec_stb_o   = active && tc;
  assign cic_clr_o   = state == FLUSH;
  assign state_o     = state;
  cic_dec_phase_cnt #(.W(RATIO_W)) u_phase (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .clr   (!active || !go),
    .ratio (ratio_q),
    .tc    (tc)
  );
  always_comb begin
    state_d = !enable_i                        ? IDLE   :
              cfg_load_i                       ? FLUSH  :
              state == IDLE                    ? FLUSH  :
              (state == FLUSH && flush_done)   ? SETTLE :
              (state == SETTLE && settle_done) ? RUN    : state;
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      ratio_q <= RATIO_W'(DEF_RATIO);
      shift_q <= '0;
    end else if (cfg_load_i) begin
      ratio_q <= ratio_i < RATIO_W'(MIN_RATIO) ? RATIO_W'(MIN_RATIO) : ratio_i;
      shift_q <= shift_i;
    end
  // cap_q marks the cycle after a strobe, when cic_data_i carries the new result
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      flush_cnt  <= '0;
      settle_cnt <= '0;
      cap_q      <= 1'b0;
    end else begin
      flush_cnt  <= (state == FLUSH && go && !flush_done) ? flush_cnt + FW'(1) : '0;
      settle_cnt <= (state == SETTLE && go) ? settle_cnt + SW'(cap_q) : '0;
      cap_q      <= dec_stb_o && go;
    end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      ovf_o       <= 1'b0;
    end else if (!go) begin
      out_valid_o <= 1'b0;
      if (cfg_load_i) ovf_o <= 1'b0;
    end else if (new_smp && (!out_valid_o || out_ready_i)) begin
      out_data_o  <= OUT_W'(sat_shift(64'(cic_data_i), 32'(shift_q), OUT_W));
      out_valid_o <= 1'b1;
    end else if (new_smp) ovf_o <= 1'b1;
    else if (out_ready_i) out_valid_o <= 1'b0;
endmodule

// File: tb/tb_cic_dec_ctrl.sv
// tb_cic_dec_ctrl: randomized and directed stimulus checked cycle by cycle against a timeline model
module tb_cic_dec_ctrl;
  localparam int OUT_W = 16, SETTLE_N = 2, FLUSH_CYCLES = 4;
  logic        clk = 0, rstn = 0, enable = 0, cfg_load = 0, out_ready = 0;
  logic [9:0]  ratio = 0;
  logic [4:0]  shift = 0;
  logic [20:0] cic_data = 0;
  logic        dec_stb, cic_clr, out_valid, ovf;
  logic [15:0] out_data;
  logic [1:0]  state;
  int n_chk = 0, n_err = 0, cyc = 0;
  bit m_run = 0, m_valid = 0, m_ovf = 0;
  int m_start = 0, m_ratio = 10, m_shift = 0, m_data = 0;
  always #5 clk = ~clk;
  cic_dec_ctrl dut (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .cfg_load_i(cfg_load),
    .ratio_i(ratio), .shift_i(shift), .cic_data_i(cic_data),
    .dec_stb_o(dec_stb), .cic_clr_o(cic_clr), .out_data_o(out_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .ovf_o(ovf), .state_o(state)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask
  function automatic int sat(input int d, input int s);
    int v;
    v = d >> s;
    return (v >> OUT_W) != 0 ? 'hFFFF : v;
  endfunction
  // Outputs are derived from the cycle offset since the restart: FLUSH_CYCLES clear cycles,
  // then strobes every ratio cycles; the first SETTLE_N captured samples are discarded.
  task automatic step(input bit en, input bit cl, input int r, input int s, input int d, input bit rdy);
    int t, p, exp_st;
    bit exp_stb, cap_run;
    @(negedge clk);
    t = cyc - m_start;
    p = t - FLUSH_CYCLES;
    exp_st = !m_run ? 0 : t < FLUSH_CYCLES ? 1 : p <= SETTLE_N * m_ratio ? 2 : 3;
    exp_stb = exp_st >= 2 && (p + 1) % m_ratio == 0;
    cap_run = exp_st == 3 && p % m_ratio == 0;
    chk("state", state, exp_st);
    chk("dec_stb", dec_stb, exp_stb);
    chk("cic_clr", cic_clr, exp_st == 1);
    chk("out_valid", out_valid, m_valid);
    chk("ovf", ovf, m_ovf);
    if (m_valid) chk("out_data", out_data, m_data);
    enable = en; cfg_load = cl; ratio = 10'(r); shift = 5'(s); cic_data = 21'(d); out_ready = rdy;
    if (cl) begin
      m_ratio = r < 2 ? 2 : r;
      m_shift = s;
      m_valid = 0;
      m_ovf = 0;
    end
    if (!en) begin
      m_run = 0;
      m_valid = 0;
    end else if (cl || !m_run) begin
      m_run = 1;
      m_start = cyc + 1;
    end else if (cap_run) begin
      if (!m_valid || rdy) begin
        m_data = sat(d, m_shift);
        m_valid = 1;
      end else m_ovf = 1;
    end else if (m_valid && rdy) m_valid = 0;
    @(posedge clk);
    cyc++;
  endtask
  function automatic int rdat();
    return int'($urandom_range(0, 32'h1FFFFF) >> $urandom_range(0, 10));
  endfunction
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_stb", dec_stb, 0);
    chk("rst_clr", cic_clr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_data", out_data, 0);
    rstn = 1;
    repeat (80) step(1, 0, 0, 0, rdat(), 1);
    step(1, 1, 1, 0, 0, 1);
    repeat (30) step(1, 0, 0, 0, rdat(), 1);
    step(1, 1, 37, 0, 0, 1);
    repeat (200) step(1, 0, 0, 0, rdat(), 1);
    step(1, 1, 4, 3, 0, 1);
    repeat (30) step(1, 0, 0, 0, 'h00F00, 1);
    step(1, 1, 4, 0, 0, 1);
    repeat (30) step(1, 0, 0, 0, 'h1FFFFF, 1);
    step(1, 1, 3, 0, 0, 1);
    repeat (30) step(1, 0, 0, 0, rdat(), 0);
    repeat (4) step(1, 0, 0, 0, rdat(), 1);
    step(1, 1, 3, 0, 0, 1);
    repeat (30) step(1, 0, 0, 0, rdat(), 1);
    repeat (3) step(0, 0, 0, 0, rdat(), 1);
    repeat (40) step(1, 0, 0, 0, rdat(), 1);
    repeat (4000)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 12),
           $urandom_range(0, 8), rdat(), $urandom_range(0, 3) != 0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    #3 rstn = 0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_clr", cic_clr, 0);
    chk("arst_stb", dec_stb, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_data", out_data, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
